// File: rtl/magma_core.sv
// Iterative GOST R 34.12-2015 "Magma" cipher: one Feistel round per clock,
// start/busy/done handshake, encrypt or decrypt chosen per operation.
module magma_core (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         decrypt,
   input  logic [63:0]  block_in,
   input  logic [255:0] key,
   output logic         busy,
   output logic         done,
   output logic [63:0]  block_out
);

   // Handshake: start is level-sampled on any edge where busy==0; done pulses
   // for one cycle with busy already low, and block_out holds until the next done.
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [63:0] PI_TAB [8] = '{
      64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F,
      64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
      64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
      64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
   };

   state_t         state;
   logic [5:0]     rnd;
   logic [31:0]    a1;
   logic [31:0]    a0;
   logic [255:0]   key_r;
   logic           dec_r;

   logic [5:0]     rnd_m1;
   logic [5:0]     rnd_rev;
   logic [2:0]     kidx;
   logic [255:0]   key_sh;
   logic [31:0]    rk;
   logic [31:0]    sum;
   logic [31:0]    sub;
   logic [31:0]    g_out;

   function automatic logic [31:0] s_sub(input logic [31:0] x);
      logic [31:0] y;
      logic [63:0] row;
      y = '0;
      for (int j = 0; j < 8; j++) begin
         row = PI_TAB[j] << (4 * int'(x[4*j +: 4]));
         y[4*j +: 4] = row[63:60];
      end
      return y;
   endfunction

   // kidx is the zero-based key word index: 0 selects K1 = key[255:224].
   always_comb begin
      rnd_m1  = rnd - 6'd1;
      rnd_rev = 6'd32 - rnd;
      kidx    = rnd_m1[2:0];
      if (!dec_r) begin
         if (rnd > 6'd24) kidx = rnd_rev[2:0];
      end else begin
         if (rnd > 6'd8) kidx = 3'd7 - rnd_m1[2:0];
      end
      key_sh = key_r >> (32 * (7 - int'(kidx)));
      rk     = key_sh[31:0];
      sum    = a0 + rk;
      sub    = s_sub(sum);
      g_out  = {sub[20:0], sub[31:21]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rnd       <= 6'd0;
         a1        <= 32'd0;
         a0        <= 32'd0;
         key_r     <= 256'd0;
         dec_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         block_out <= 64'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a1    <= block_in[63:32];
                  a0    <= block_in[31:0];
                  key_r <= key;
                  dec_r <= decrypt;
                  rnd   <= 6'd1;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (rnd == 6'd32) begin
                  // Final round omits the half swap.
                  block_out <= {a1 ^ g_out, a0};
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  rnd       <= 6'd0;
                  state     <= IDLE;
               end else begin
                  a1  <= a0;
                  a0  <= a1 ^ g_out;
                  rnd <= rnd + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_magma_core.sv
// Directed and randomized bench for magma_core against a whole-block reference
// model built from the standard's key schedule and round definition.
module tb_magma_core;

   logic         clk;
   logic         reset;
   logic         start;
   logic         decrypt;
   logic [63:0]  block_in;
   logic [255:0] key_in;
   logic         busy;
   logic         done;
   logic [63:0]  block_out;

   int tests  = 0;
   int failed = 0;

   logic [63:0] exp_q[$];

   localparam logic [255:0] TV_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0]  TV_PT  = 64'hfedcba9876543210;
   localparam logic [63:0]  TV_CT  = 64'h4ee901e5c2d8ca3d;

   magma_core dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .decrypt   (decrypt),
      .block_in  (block_in),
      .key       (key_in),
      .busy      (busy),
      .done      (done),
      .block_out (block_out)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
      logic [63:0] pi [8];
      logic [31:0] t;
      logic [31:0] s;
      logic [63:0] row;
      pi[0] = 64'hC462A5B9E8D703F1; pi[1] = 64'h68239A5C1E47BD0F;
      pi[2] = 64'hB3582FADE174C960; pi[3] = 64'hC821D4F670A53E9B;
      pi[4] = 64'h7F5A816D093EB42C; pi[5] = 64'h5DF692CAB78143E0;
      pi[6] = 64'h8E25691CF4B0DA37; pi[7] = 64'h17ED05834FA69CB2;
      t = a + k;
      s = '0;
      for (int j = 0; j < 8; j++) begin
         row = pi[j] >> (60 - 4 * int'((t >> (4 * j)) & 32'hF));
         s = s | ((32'(row) & 32'hF) << (4 * j));
      end
      return (s << 11) | (s >> 21);
   endfunction

   function automatic logic [63:0] ref_magma(input logic [255:0] k, input logic [63:0] b,
                                             input logic d);
      logic [31:0] kw [1:8];
      int          sched[$];
      logic [31:0] a1;
      logic [31:0] a0;
      logic [31:0] t;
      for (int n = 1; n <= 8; n++) kw[n] = k[255 - 32 * (n - 1) -: 32];
      if (!d) begin
         for (int p = 0; p < 3; p++) for (int n = 1; n <= 8; n++) sched.push_back(n);
         for (int n = 8; n >= 1; n--) sched.push_back(n);
      end else begin
         for (int n = 1; n <= 8; n++) sched.push_back(n);
         for (int p = 0; p < 3; p++) for (int n = 8; n >= 1; n--) sched.push_back(n);
      end
      a1 = b[63:32];
      a0 = b[31:0];
      for (int r = 0; r < 32; r++) begin
         t = a1 ^ ref_g(a0, kw[sched[r]]);
         if (r < 31) begin
            a1 = a0;
            a0 = t;
         end else begin
            a1 = t;
         end
      end
      return {a1, a0};
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic do_op(input logic [255:0] k, input logic [63:0] b, input logic d,
                        input string tag, output logic [63:0] res);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      key_in   = k;
      block_in = b;
      decrypt  = d;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, 64'(lat), 64'd32);
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      res = block_out;
   endtask

   function automatic logic [255:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] res;
      logic [63:0] res3;
      logic [255:0] rk;
      logic [63:0]  rb;
      int ndone;
      int dcyc;
      int c;
      int nd;
      int d [3];
      int lowcnt [2];

      reset    = 1'b0;
      start    = 1'b0;
      decrypt  = 1'b0;
      block_in = '0;
      key_in   = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_block_out", block_out, 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1 encrypt, 2 decrypt
      do_op(TV_KEY, TV_PT, 1'b0, "t1_enc", res);
      chk("t1_result", res, TV_CT);
      @(negedge clk);
      chk("t1_done_one_cycle", 64'(done), 64'd0);
      chk("t1_hold", block_out, TV_CT);
      do_op(TV_KEY, TV_CT, 1'b1, "t2_dec", res);
      chk("t2_result", res, TV_PT);

      // 3 busy protection
      @(negedge clk);
      start = 1'b1; key_in = TV_KEY; block_in = TV_PT; decrypt = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      ndone = 0; dcyc = 0; res3 = '0;
      for (int cc = 1; cc <= 45; cc++) begin
         start = (cc == 5 || cc == 32);
         if (start) begin
            key_in   = rand_key();
            block_in = {$urandom, $urandom};
            decrypt  = 1'b1;
         end
         if (cc == 10) begin
            key_in   = '0;
            block_in = '1;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            ndone++;
            res3 = block_out;
            dcyc = cc;
         end
      end
      start = 1'b0;
      chk("t3_done_count", 64'(ndone), 64'd1);
      chk("t3_done_cycle", 64'(dcyc), 64'd32);
      chk("t3_result", res3, TV_CT);

      // 4 asynchronous reset mid-run
      @(negedge clk);
      start = 1'b1; key_in = TV_KEY; block_in = TV_PT; decrypt = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (17) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_done", 64'(done), 64'd0);
      chk("t4_block_out", block_out, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      for (int cc = 0; cc < 40; cc++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("t4_no_done", 64'(ndone), 64'd0);
      chk("t4_idle_busy", 64'(busy), 64'd0);
      do_op(TV_KEY, TV_PT, 1'b0, "t4_fresh", res);
      chk("t4_fresh_result", res, TV_CT);

      // 5 held start: three back-to-back operations
      @(negedge clk);
      start = 1'b1; key_in = TV_KEY; block_in = TV_PT; decrypt = 1'b0;
      c = 0; nd = 0; lowcnt[0] = 0; lowcnt[1] = 0;
      d[0] = 0; d[1] = 0; d[2] = 0;
      while (nd < 3 && c < 120) begin
         @(posedge clk);
         c++;
         @(negedge clk);
         if (done) begin
            d[nd] = c;
            nd++;
            chk("t5_result", block_out, TV_CT);
            if (nd == 3) start = 1'b0;
         end
         if (!busy && nd >= 1 && nd < 3) lowcnt[nd - 1]++;
      end
      start = 1'b0;
      chk("t5_done_count", 64'(nd), 64'd3);
      chk("t5_first_done", 64'(d[0]), 64'd33);
      chk("t5_gap1", 64'(d[1] - d[0]), 64'd33);
      chk("t5_gap2", 64'(d[2] - d[1]), 64'd33);
      chk("t5_low1", 64'(lowcnt[0]), 64'd1);
      chk("t5_low2", 64'(lowcnt[1]), 64'd1);
      repeat (3) @(negedge clk);
      chk("t5_stopped", 64'(busy), 64'd0);

      // 6 random round trips against the model
      chk("model_tv", ref_magma(TV_KEY, TV_PT, 1'b0), TV_CT);
      for (int i = 0; i < 200; i++) begin
         rk = rand_key();
         rb = {$urandom, $urandom};
         exp_q.push_back(ref_magma(rk, rb, 1'b0));
         do_op(rk, rb, 1'b0, "t6_enc", res);
         chk("t6_enc_model", res, exp_q.pop_front());
         exp_q.push_back(rb);
         do_op(rk, res, 1'b1, "t6_dec", res);
         chk("t6_roundtrip", res, exp_q.pop_front());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
